load_store_unit: RTL and testbench

Sequential data-memory access stage for the MIPS core. It sits directly downstream of `control_unit` and consumes `mem_read`, `mem_write`, `mem_mode` and `mem_sign_ext` together with the ALU address and the rt store data. It drives a word-wide request/acknowledge data bus, steering byte and halfword lanes on the way out and extracting and extending them on the way back. While an access is in flight it holds the core with `stall`.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory access sizes, LSU states, opcodes.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   MEM_WORD / MEM_HALF / MEM_BYTE  mem_mode encodings (2'b11 is reserved and behaves as word)
//   lsu_state_t                     load/store unit FSM states
//   OP_*                            primary opcode values decoded by control_unit
//   is_word_mode()                  true for word and reserved mem_mode encodings
package mips_pkg;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Reserved encoding 2'b11 falls into the word case.
  function automatic logic is_word_mode(input logic [1:0] mode);
    return (mode != MEM_HALF) && (mode != MEM_BYTE);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extract/extend for loads (little-endian).
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   st_mode, st_lane, st_we, st_wdata  -> st_be, st_bus_wdata   store steering (loads get be=1111, data 0)
//   ld_mode, ld_lane, ld_sign_ext, ld_bus_rdata -> ld_data      load extraction and extension
module lsu_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_mode,
  input  logic [1:0]  st_lane,
  input  logic        st_we,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_bus_wdata,
  input  logic [1:0]  ld_mode,
  input  logic [1:0]  ld_lane,
  input  logic        ld_sign_ext,
  input  logic [31:0] ld_bus_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Sub-word stores replicate the datum across lanes; be picks the live lane.
  always_comb begin
    st_be        = 4'b1111;
    st_bus_wdata = '0;
    if (st_we) begin
      case (st_mode)
        MEM_BYTE: begin
          st_be        = 4'b0001 << st_lane;
          st_bus_wdata = {4{st_wdata[7:0]}};
        end
        MEM_HALF: begin
          // addr[0] is ignored: a halfword always lands on a half boundary.
          st_be        = st_lane[1] ? 4'b1100 : 4'b0011;
          st_bus_wdata = {2{st_wdata[15:0]}};
        end
        default: begin
          st_be        = 4'b1111;
          st_bus_wdata = st_wdata;
        end
      endcase
    end
  end

  assign byte_sel = ld_bus_rdata[{ld_lane, 3'b000} +: 8];
  assign half_sel = ld_bus_rdata[{ld_lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ld_bus_rdata;
    case (ld_mode)
      MEM_BYTE: ld_data = {{24{ld_sign_ext & byte_sel[7]}}, byte_sel};
      MEM_HALF: ld_data = {{16{ld_sign_ext & half_sel[15]}}, half_sel};
      default:  ld_data = ld_bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one req/ack bus cycle per load/store and stalls the core meanwhile.
// Latency: 3 cycles minimum (IDLE detect, REQ with ack, DONE); +1 per bus wait state; timeout after TIMEOUT_CYCLES REQ cycles.
// Backpressure: stall held from request detect through REQ; bus wait states stretch REQ.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned word/half accesses trap instead of issuing a bus cycle).
// Ports:
//   clk, rst                                    clock, async active-high reset
//   mem_read, mem_write, mem_mode, mem_sign_ext  access request from control_unit (both high = store)
//   addr, wdata                                  byte address and store data
//   stall, rdata, rdata_valid                    core hold, registered load result and its valid
//   misalign_err, bus_err                        one-cycle error pulses in DONE
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata registered bus request, held for all of REQ
//   bus_rdata, bus_ack                           bus response, sampled only in REQ
module load_store_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_mode,
  input  logic        mem_sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  // wait_cnt holds completed wait cycles, so REQ cycle number k sees wait_cnt == k-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             req_load;
  logic [1:0]       req_mode;
  logic [1:0]       req_lane;
  logic             req_sext;
  logic             access;
  logic             misalign;
  logic             timeout;
  logic             misalign_q;
  logic [3:0]       st_be;
  logic [31:0]      st_bus_wdata;
  logic [31:0]      ld_data;

  assign access = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = access &&
                    ((is_word_mode(mem_mode) && (addr[1:0] != 2'b00)) ||
                     ((mem_mode == MEM_HALF) && addr[0]));
`else
  assign misalign = 1'b0;
`endif

  // An ack in the last allowed cycle wins over the timeout.
  assign timeout = (state == LSU_REQ) && !bus_ack && (wait_cnt == CNT_LAST);

  lsu_lane_align u_align (
    .st_mode      (mem_mode),
    .st_lane      (addr[1:0]),
    .st_we        (mem_write),
    .st_wdata     (wdata),
    .st_be        (st_be),
    .st_bus_wdata (st_bus_wdata),
    .ld_mode      (req_mode),
    .ld_lane      (req_lane),
    .ld_sign_ext  (req_sext),
    .ld_bus_rdata (bus_rdata),
    .ld_data      (ld_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (access) state_nxt = misalign ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (bus_ack || timeout) state_nxt = LSU_DONE;
      LSU_DONE: state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    stall = 1'b0;
    case (state)
      LSU_IDLE: stall = access;
      LSU_REQ:  stall = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  // Request capture, bus registers, result and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      req_load    <= 1'b0;
      req_mode    <= MEM_WORD;
      req_lane    <= 2'b00;
      req_sext    <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      misalign_q  <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (access) begin
            req_load <= ~mem_write;
            req_mode <= mem_mode;
            req_lane <= addr[1:0];
            req_sext <= mem_sign_ext;
            wait_cnt <= '0;
            if (misalign) begin
              misalign_q  <= 1'b1;
              rdata       <= '0;
              rdata_valid <= ~mem_write;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= st_be;
              bus_wdata <= st_bus_wdata;
            end
          end
        end
        LSU_REQ: begin
          if (bus_ack || timeout) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            bus_err     <= timeout;
            rdata_valid <= req_load;
            if (timeout)       rdata <= '0;
            else if (req_load) rdata <= ld_data;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_sign_ext;
  logic [1:0]  mem_mode;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, misalign_err, bus_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_mode(mem_mode), .mem_sign_ext(mem_sign_ext),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  mode;
    logic        sext;
    logic [31:0] addr, wdata, brdata;
    int          ack_cyc;   // REQ cycle (1-based) in which ack is driven; 0 = never
    logic [3:0]  be;
    logic [31:0] bwdata, baddr;
    logic        we;
    int          req_cyc;   // expected number of REQ cycles
    logic        chk_rd;    // compare rdata
    logic [31:0] rdata;
    logic        chk_rv;    // compare rdata_valid
    logic        rvalid;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at posedge+#1 with the DUT in IDLE; ends at posedge+#1 back in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int          n;
    int          stall_cnt;
    logic        stable;
    logic [3:0]  be_s;
    logic [31:0] wd_s, ad_s;
    logic        we_s;
    mem_read = v.rd; mem_write = v.wr; mem_mode = v.mode; mem_sign_ext = v.sext;
    addr = v.addr; wdata = v.wdata;
    #1;
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    be_s = bus_be; wd_s = bus_wdata; ad_s = bus_addr; we_s = bus_we;
    stable = 1'b1;
    n = 1;
    while (bus_req === 1'b1 && n <= 40) begin
      if (stall === 1'b1) stall_cnt++;
      if (bus_be !== be_s || bus_wdata !== wd_s || bus_addr !== ad_s || bus_we !== we_s) stable = 1'b0;
      if (n == v.ack_cyc) begin bus_ack = 1'b1; bus_rdata = v.brdata; end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'h5A5A_C3C3;
      n++;
    end
    chk($sformatf("v%0d bus_be", idx), {28'd0, be_s}, {28'd0, v.be});
    chk($sformatf("v%0d bus_wdata", idx), wd_s, v.bwdata);
    chk($sformatf("v%0d bus_addr", idx), ad_s, v.baddr);
    chk($sformatf("v%0d bus_we", idx), {31'd0, we_s}, {31'd0, v.we});
    chk($sformatf("v%0d bus stable", idx), {31'd0, stable}, 32'd1);
    chk($sformatf("v%0d req cycles", idx), n - 1, v.req_cyc);
    chk($sformatf("v%0d stall cycles", idx), stall_cnt, v.req_cyc + 1);
    // Now in DONE
    chk($sformatf("v%0d done stall", idx), {31'd0, stall}, 32'd0);
    chk($sformatf("v%0d done bus_req", idx), {31'd0, bus_req}, 32'd0);
    chk($sformatf("v%0d bus_err", idx), {31'd0, bus_err}, {31'd0, v.err});
    chk($sformatf("v%0d misalign_err", idx), {31'd0, misalign_err}, 32'd0);
    if (v.chk_rv) chk($sformatf("v%0d rdata_valid", idx), {31'd0, rdata_valid}, {31'd0, v.rvalid});
    if (v.chk_rd) chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d pulses cleared", idx), {30'd0, rdata_valid, bus_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rd  wr  mode  sx addr          wdata         brdata        ack be       bwdata        baddr         we  rq chkrd rdata         chkrv rv  err
    vecs[0]  = '{1'b0,1'b1,2'b10,1'b0,32'h0000_1003,32'h0000_00A5,32'h0,        1, 4'b1000,32'hA5A5_A5A5,32'h0000_1000,1'b1, 1,1'b0,32'h0,        1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,2'b10,1'b1,32'h0000_0002,32'h0,        32'h0080_0000,1, 4'b1111,32'h0,        32'h0,        1'b0, 1,1'b1,32'hFFFF_FF80,1'b1,1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b0,2'b10,1'b0,32'h0000_0002,32'h0,        32'h0080_0000,1, 4'b1111,32'h0,        32'h0,        1'b0, 1,1'b1,32'h0000_0080,1'b1,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,2'b01,1'b1,32'h0000_0002,32'h0,        32'hBEEF_1234,1, 4'b1111,32'h0,        32'h0,        1'b0, 1,1'b1,32'hFFFF_BEEF,1'b1,1'b1,1'b0};
    vecs[4]  = '{1'b1,1'b0,2'b01,1'b0,32'h0000_0002,32'h0,        32'hBEEF_1234,1, 4'b1111,32'h0,        32'h0,        1'b0, 1,1'b1,32'h0000_BEEF,1'b1,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,2'b00,1'b1,32'h0000_0004,32'h0,        32'hBEEF_1234,1, 4'b1111,32'h0,        32'h0000_0004,1'b0, 1,1'b1,32'hBEEF_1234,1'b1,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b1,2'b01,1'b0,32'h0000_0102,32'h1234_ABCD,32'h0,        1, 4'b1100,32'hABCD_ABCD,32'h0000_0100,1'b1, 1,1'b0,32'h0,        1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,2'b00,1'b0,32'h0000_0200,32'hCAFE_F00D,32'h0,        3, 4'b1111,32'hCAFE_F00D,32'h0000_0200,1'b1, 3,1'b0,32'h0,        1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,2'b10,1'b1,32'h0000_0001,32'h0,        32'h0000_7F00,2, 4'b1111,32'h0,        32'h0,        1'b0, 2,1'b1,32'h0000_007F,1'b1,1'b1,1'b0};
    vecs[9]  = '{1'b1,1'b0,2'b11,1'b1,32'h0000_0008,32'h0,        32'h89AB_CDEF,1, 4'b1111,32'h0,        32'h0000_0008,1'b0, 1,1'b1,32'h89AB_CDEF,1'b1,1'b1,1'b0};
    vecs[10] = '{1'b1,1'b1,2'b10,1'b0,32'h0000_0001,32'h0000_003C,32'h0,        1, 4'b0010,32'h3C3C_3C3C,32'h0,        1'b1, 1,1'b0,32'h0,        1'b1,1'b0,1'b0};
    // Timeout: rdata was 0x89ABCDEF before, must be cleared.
    vecs[11] = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0010,32'h0,        32'h0,        0, 4'b1111,32'h0,        32'h0000_0010,1'b0,15,1'b1,32'h0,        1'b0,1'b0,1'b1};
    // Ack in the 15th REQ cycle beats the timeout.
    vecs[12] = '{1'b1,1'b0,2'b01,1'b0,32'h0000_0000,32'h0,        32'h0000_8001,15,4'b1111,32'h0,        32'h0,        1'b0,15,1'b1,32'h0000_8001,1'b1,1'b1,1'b0};

    rst = 1'b1; mem_read = 0; mem_write = 0; mem_mode = 2'b00; mem_sign_ext = 0;
    addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset flags", {28'd0, rdata_valid, bus_err, misalign_err, bus_we}, 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset bus_be/wdata", {bus_wdata[27:0], bus_be}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ack outside REQ is ignored
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("idle ack bus_req", {31'd0, bus_req}, 32'd0);
    chk("idle ack rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("idle ack rdata", rdata, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Misaligned word load at 0x6
    begin
`ifdef LSU_MISALIGN_TRAP_EN
      logic saw_req;
      mem_read = 1'b1; mem_write = 1'b0; mem_mode = 2'b00; mem_sign_ext = 1'b0; addr = 32'h6;
      #1;
      chk("mis stall idle", {31'd0, stall}, 32'd1);
      saw_req = bus_req;
      @(posedge clk); #1;
      mem_read = 1'b0;
      saw_req = saw_req | bus_req;
      chk("mis misalign_err", {31'd0, misalign_err}, 32'd1);
      chk("mis rdata", rdata, 32'd0);
      chk("mis stall done", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      saw_req = saw_req | bus_req;
      chk("mis pulse cleared", {31'd0, misalign_err}, 32'd0);
      chk("mis no bus_req", {31'd0, saw_req}, 32'd0);
`else
      vec_t m;
      m = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0006,32'h0,32'h1357_9BDF,1,4'b1111,32'h0,32'h0000_0004,1'b0,1,1'b1,32'h1357_9BDF,1'b1,1'b1,1'b0};
      run_vec(20, m);
`endif
    end

    // Reset during the second REQ cycle
    mem_read = 1'b1; mem_write = 1'b0; mem_mode = 2'b00; addr = 32'h20;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    chk("rst-mid bus_req before", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst-mid bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst-mid stall", {31'd0, stall}, 32'd0);
    chk("rst-mid rdata_valid", {31'd0, rdata_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      logic any;
      any = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        any = any | bus_req | rdata_valid | stall;
      end
      chk("rst-mid no retry", {31'd0, any}, 32'd0);
    end
    begin
      vec_t r;
      r = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0040,32'h0,32'h0BAD_F00D,1,4'b1111,32'h0,32'h0000_0040,1'b0,1,1'b1,32'h0BAD_F00D,1'b1,1'b1,1'b0};
      run_vec(30, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
